// File: rtl/lvds_rx_deframer.sv
`default_nettype none
// ============================================================================
//  Module   : lvds_rx_deframer
//  Purpose  : LVDS receive link layer that bit-slips to the training byte,
//             waits for sync, and packs MSB-first bytes into a 32-bit FIFO.
//  Revision : 1.0  initial release
// ============================================================================
module lvds_rx_deframer #(
    parameter logic [7:0]  TRAIN_BYTE    = 8'h35,
    parameter logic [7:0]  SYNC_BYTE     = 8'h77,
    parameter logic [31:0] IDLE_WORD     = 32'h52525252,
    parameter int          DROP_IDLE     = 1,
    parameter int          SLIP_WAIT     = 4,
    parameter int          CONFIRM_COUNT = 8,
    parameter int          FIFO_DEPTH    = 4
) (
    input  logic        rx_inclock,
    input  logic        pll_areset,
    input  logic        rx_locked,
    input  logic [7:0]  rx_out,
    output logic        rx_data_align,
    output logic        rx_align_done,
    output logic [31:0] deq_rx_get,
    output logic        RDY_deq_rx_get,
    input  logic        EN_deq_rx_get,
    output logic        rx_overflow
);

    localparam int c_PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_CNT_W   = c_PTR_W + 1;
    localparam int c_WAIT_W  = (SLIP_WAIT > 1) ? $clog2(SLIP_WAIT + 1) : 1;
    localparam int c_MATCH_W = (CONFIRM_COUNT > 1) ? $clog2(CONFIRM_COUNT + 1) : 1;

    localparam logic [c_WAIT_W-1:0]  c_WAIT_LAST  = c_WAIT_W'(SLIP_WAIT - 1);
    localparam logic [c_MATCH_W-1:0] c_MATCH_LAST = c_MATCH_W'(CONFIRM_COUNT - 1);
    localparam logic [c_CNT_W-1:0]   c_FULL       = c_CNT_W'(FIFO_DEPTH);

    localparam logic [2:0] S_WAIT_LOCK = 3'd0;
    localparam logic [2:0] S_HUNT      = 3'd1;
    localparam logic [2:0] S_SLIP_WAIT = 3'd2;
    localparam logic [2:0] S_CONFIRM   = 3'd3;
    localparam logic [2:0] S_WAIT_SYNC = 3'd4;
    localparam logic [2:0] S_DATA      = 3'd5;

    logic [2:0]           r_state;
    logic [2:0]           w_state_nxt;
    logic [c_WAIT_W-1:0]  r_wait;
    logic [c_WAIT_W-1:0]  w_wait_nxt;
    logic [c_MATCH_W-1:0] r_match;
    logic [c_MATCH_W-1:0] w_match_nxt;
    logic [1:0]           r_idx;
    logic [1:0]           w_idx_nxt;
    logic [23:0]          r_shift;
    logic [23:0]          w_shift_nxt;
    logic                 w_slip;
    logic                 w_wr_req;
    logic [31:0]          w_word;
    logic                 r_data_align;
    logic                 r_align_done;

    logic [31:0]          r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_PTR_W-1:0]   w_wr_nxt;
    logic [c_PTR_W-1:0]   w_rd_nxt;
    logic [c_CNT_W-1:0]   r_count;
    logic [c_CNT_W-1:0]   w_count_nxt;
    logic [31:0]          r_head;
    logic [31:0]          w_head_nxt;
    logic                 r_rdy;
    logic                 r_ovf;
    logic                 w_full;
    logic                 w_pop;
    logic                 w_wr_acc;
    logic                 w_ovf_set;

    // Link-training and framing state machine
    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait;
        w_match_nxt = r_match;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_slip      = 1'b0;
        w_wr_req    = 1'b0;
        w_word      = {r_shift, rx_out};

        if (r_state != S_WAIT_LOCK && !rx_locked) begin
            w_state_nxt = S_WAIT_LOCK;
            w_idx_nxt   = 2'd0;
        end else begin
            case (r_state)
                S_WAIT_LOCK: begin
                    if (rx_locked) w_state_nxt = S_HUNT;
                end
                S_HUNT: begin
                    if (rx_out == TRAIN_BYTE) begin
                        w_match_nxt = c_MATCH_W'(1);
                        w_state_nxt = (CONFIRM_COUNT == 1) ? S_WAIT_SYNC : S_CONFIRM;
                    end else begin
                        w_slip      = 1'b1;
                        w_wait_nxt  = '0;
                        w_state_nxt = S_SLIP_WAIT;
                    end
                end
                S_SLIP_WAIT: begin
                    if (r_wait == c_WAIT_LAST) w_state_nxt = S_HUNT;
                    else                       w_wait_nxt  = r_wait + 1'b1;
                end
                S_CONFIRM: begin
                    if (rx_out != TRAIN_BYTE)       w_state_nxt = S_HUNT;
                    else if (r_match == c_MATCH_LAST) w_state_nxt = S_WAIT_SYNC;
                    else                            w_match_nxt = r_match + 1'b1;
                end
                S_WAIT_SYNC: begin
                    if (rx_out == SYNC_BYTE) begin
                        w_state_nxt = S_DATA;
                        w_idx_nxt   = 2'd0;
                    end
                end
                S_DATA: begin
                    w_shift_nxt = {r_shift[15:0], rx_out};
                    w_idx_nxt   = r_idx + 1'b1;
                    if (r_idx == 2'd3)
                        w_wr_req = !((DROP_IDLE != 0) && (w_word == IDLE_WORD));
                end
                default: w_state_nxt = S_WAIT_LOCK;
            endcase
        end
    end

    // Show-ahead FIFO; head and ready are precomputed so outputs come from flops
    always_comb begin
        w_full    = (r_count == c_FULL);
        w_pop     = EN_deq_rx_get && r_rdy;
        w_wr_acc  = w_wr_req && (!w_full || w_pop);
        w_ovf_set = w_wr_req && w_full && !w_pop;
        w_rd_nxt  = w_pop    ? r_rd_ptr + 1'b1 : r_rd_ptr;
        w_wr_nxt  = w_wr_acc ? r_wr_ptr + 1'b1 : r_wr_ptr;
        case ({w_wr_acc, w_pop})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
        if (w_count_nxt == '0)
            w_head_nxt = '0;
        else if (w_wr_acc && (r_wr_ptr == w_rd_nxt))
            w_head_nxt = w_word;
        else
            w_head_nxt = r_mem[w_rd_nxt];
    end

    always_ff @(posedge rx_inclock) begin
        if (w_wr_acc) r_mem[r_wr_ptr] <= w_word;
    end

    always_ff @(posedge rx_inclock or posedge pll_areset) begin
        if (pll_areset) begin
            r_state      <= S_WAIT_LOCK;
            r_wait       <= '0;
            r_match      <= '0;
            r_idx        <= 2'd0;
            r_shift      <= '0;
            r_data_align <= 1'b0;
            r_align_done <= 1'b0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_head       <= '0;
            r_rdy        <= 1'b0;
            r_ovf        <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_wait       <= w_wait_nxt;
            r_match      <= w_match_nxt;
            r_idx        <= w_idx_nxt;
            r_shift      <= w_shift_nxt;
            r_data_align <= w_slip;
            r_align_done <= (w_state_nxt == S_WAIT_SYNC) || (w_state_nxt == S_DATA);
            r_wr_ptr     <= w_wr_nxt;
            r_rd_ptr     <= w_rd_nxt;
            r_count      <= w_count_nxt;
            r_head       <= w_head_nxt;
            r_rdy        <= (w_count_nxt != '0);
            if (w_ovf_set) r_ovf <= 1'b1;
        end
    end

    assign rx_data_align  = r_data_align;
    assign rx_align_done  = r_align_done;
    assign deq_rx_get     = r_head;
    assign RDY_deq_rx_get = r_rdy;
    assign rx_overflow    = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_lvds_rx_deframer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lvds_rx_deframer
//  Purpose  : Directed, table-driven bench for lvds_rx_deframer.
//  Revision : 1.0  initial release
// ============================================================================
module tb_lvds_rx_deframer;

    logic        rx_inclock = 1'b0;
    logic        pll_areset = 1'b1;
    logic        rx_locked  = 1'b0;
    logic [7:0]  rx_out     = 8'h00;
    logic        EN_deq_rx_get = 1'b0;
    logic        rx_data_align;
    logic        rx_align_done;
    logic [31:0] deq_rx_get;
    logic        RDY_deq_rx_get;
    logic        rx_overflow;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        locked;
        logic [7:0]  rx;
        logic        en;
        logic        e_align;
        logic        e_done;
        logic        e_rdy;
        logic        e_ovf;
        logic [31:0] e_data;
    } vec_t;

    vec_t vecs[$];

    lvds_rx_deframer dut (
        .rx_inclock     (rx_inclock),
        .pll_areset     (pll_areset),
        .rx_locked      (rx_locked),
        .rx_out         (rx_out),
        .rx_data_align  (rx_data_align),
        .rx_align_done  (rx_align_done),
        .deq_rx_get     (deq_rx_get),
        .RDY_deq_rx_get (RDY_deq_rx_get),
        .EN_deq_rx_get  (EN_deq_rx_get),
        .rx_overflow    (rx_overflow)
    );

    always #5 rx_inclock = ~rx_inclock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge rx_inclock);
        #1;
    endtask

    task automatic add_vec(input logic l, input logic [7:0] rx, input logic en,
                           input logic al, input logic dn, input logic rdy,
                           input logic ovf, input logic [31:0] data);
        vec_t v;
        v.locked = l; v.rx = rx; v.en = en; v.e_align = al;
        v.e_done = dn; v.e_rdy = rdy; v.e_ovf = ovf; v.e_data = data;
        vecs.push_back(v);
    endtask

    task automatic do_reset(input string name);
        EN_deq_rx_get = 1'b0;
        rx_locked     = 1'b0;
        rx_out        = 8'h00;
        pll_areset    = 1'b1;
        #2;
        check({name, "_reset"},
              {rx_data_align, rx_align_done, RDY_deq_rx_get, rx_overflow, deq_rx_get},
              {4'b0000, 32'h0});
        @(posedge rx_inclock);
        #1;
        pll_areset = 1'b0;
    endtask

    // Feed training bytes until alignment (bounded), then the sync byte
    task automatic train(input string name);
        int n;
        rx_locked = 1'b1;
        rx_out    = 8'h35;
        n = 0;
        while (!rx_align_done && n < 40) begin
            tick();
            n++;
        end
        check({name, "_aligned"}, {63'd0, rx_align_done}, 64'd1);
        rx_out = 8'h77;
        tick();
    endtask

    task automatic push_word(input logic [31:0] w, input logic en_last);
        for (int b = 0; b < 4; b++) begin
            rx_out        = w[31 - 8*b -: 8];
            EN_deq_rx_get = (b == 3) ? en_last : 1'b0;
            tick();
        end
        EN_deq_rx_get = 1'b0;
    endtask

    task automatic pop_expect(input string name, input logic rdy, input logic [31:0] data);
        rx_out        = 8'h52;
        EN_deq_rx_get = 1'b1;
        tick();
        EN_deq_rx_get = 1'b0;
        check(name, {RDY_deq_rx_get, deq_rx_get}, {rdy, data});
    endtask

    localparam logic [31:0] c_W1 = 32'h11223344;
    localparam logic [31:0] c_W2 = 32'h55667788;
    localparam logic [31:0] c_W3 = 32'h99AABBCC;
    localparam logic [31:0] c_W4 = 32'hDDEEFF01;
    localparam logic [31:0] c_W5 = 32'h0A0B0C0D;

    initial begin
        // In WAIT_LOCK, then 8 training matches, sync, one data word and idles
        add_vec(0, 8'h35, 0, 0, 0, 0, 0, 32'h0);
        add_vec(0, 8'h35, 0, 0, 0, 0, 0, 32'h0);
        for (int i = 0; i < 8; i++) add_vec(1, 8'h35, 0, 0, 0, 0, 0, 32'h0);
        add_vec(1, 8'h35, 0, 0, 1, 0, 0, 32'h0);
        add_vec(1, 8'hA5, 0, 0, 1, 0, 0, 32'h0);
        add_vec(1, 8'h77, 0, 0, 1, 0, 0, 32'h0);
        add_vec(1, 8'hDE, 0, 0, 1, 0, 0, 32'h0);
        add_vec(1, 8'hAD, 0, 0, 1, 0, 0, 32'h0);
        add_vec(1, 8'hBE, 0, 0, 1, 0, 0, 32'h0);
        add_vec(1, 8'hEF, 0, 0, 1, 1, 0, 32'hDEADBEEF);
        for (int i = 0; i < 4; i++) add_vec(1, 8'h52, 0, 0, 1, 1, 0, 32'hDEADBEEF);
        add_vec(1, 8'h00, 1, 0, 1, 0, 0, 32'h0);
        add_vec(1, 8'h11, 1, 0, 1, 0, 0, 32'h0);

        do_reset("t1");
        for (int i = 0; i < vecs.size(); i++) begin
            rx_locked     = vecs[i].locked;
            rx_out        = vecs[i].rx;
            EN_deq_rx_get = vecs[i].en;
            tick();
            check($sformatf("vec%0d", i),
                  {rx_data_align, rx_align_done, RDY_deq_rx_get, rx_overflow, deq_rx_get},
                  {vecs[i].e_align, vecs[i].e_done, vecs[i].e_rdy, vecs[i].e_ovf, vecs[i].e_data});
        end
        EN_deq_rx_get = 1'b0;

        // Misaligned pattern at three HUNT compare points, then training
        do_reset("t2");
        rx_locked = 1'b1;
        for (int t = 1; t <= 40; t++) begin
            rx_out = (t <= 12) ? 8'h9A : 8'h35;
            tick();
            check($sformatf("slip_t%0d", t), {63'd0, rx_data_align},
                  {63'd0, (t == 2 || t == 7 || t == 12)});
            check($sformatf("done_t%0d", t), {63'd0, rx_align_done}, {63'd0, (t >= 24)});
        end

        // Overflow: five words into a four-entry FIFO, then drain
        do_reset("t4");
        train("t4");
        push_word(c_W1, 1'b0);
        push_word(c_W2, 1'b0);
        push_word(c_W3, 1'b0);
        push_word(c_W4, 1'b0);
        check("t4_full_no_ovf", {RDY_deq_rx_get, rx_overflow, deq_rx_get}, {2'b10, c_W1});
        push_word(c_W5, 1'b0);
        check("t4_ovf", {RDY_deq_rx_get, rx_overflow, deq_rx_get}, {2'b11, c_W1});
        pop_expect("t4_pop1", 1'b1, c_W2);
        pop_expect("t4_pop2", 1'b1, c_W3);
        pop_expect("t4_pop3", 1'b1, c_W4);
        pop_expect("t4_pop4", 1'b0, 32'h0);
        check("t4_ovf_sticky", {63'd0, rx_overflow}, 64'd1);

        // Full FIFO with simultaneous write and pop
        do_reset("t5");
        train("t5");
        push_word(c_W1, 1'b0);
        push_word(c_W2, 1'b0);
        push_word(c_W3, 1'b0);
        push_word(c_W4, 1'b0);
        push_word(c_W5, 1'b1);
        check("t5_wr_pop_full", {RDY_deq_rx_get, rx_overflow, deq_rx_get}, {2'b10, c_W2});
        pop_expect("t5_pop1", 1'b1, c_W3);
        pop_expect("t5_pop2", 1'b1, c_W4);
        pop_expect("t5_pop3", 1'b1, c_W5);
        pop_expect("t5_pop4", 1'b0, 32'h0);
        check("t5_no_ovf", {63'd0, rx_overflow}, 64'd0);

        // Lock loss mid-word, relock, fresh word assembly
        do_reset("t6");
        train("t6");
        push_word(c_W1, 1'b0);
        rx_out = 8'h12; tick();
        rx_out = 8'h34; tick();
        rx_locked = 1'b0;
        rx_out    = 8'h56;
        tick();
        check("t6_unlock", {rx_data_align, rx_align_done, RDY_deq_rx_get, deq_rx_get},
              {3'b001, c_W1});
        rx_out = 8'h35;
        tick();
        check("t6_stay_lock", {63'd0, rx_align_done}, 64'd0);
        train("t6b");
        push_word(32'hCAFEF00D, 1'b0);
        check("t6_head_kept", {RDY_deq_rx_get, deq_rx_get}, {1'b1, c_W1});
        pop_expect("t6_fresh_word", 1'b1, 32'hCAFEF00D);
        pop_expect("t6_empty", 1'b0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
